// File: rtl/ddr_wr_arb_rr_if.sv
// Bundle of the write arbiter's slave-FIFO side and ddr_wr_ctrl side signals.
// The master modport is the arbiter's view; the slave modport is its surroundings.
interface ddr_wr_arb_rr_if #(
  parameter int unsigned CH_NUM = 10,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned DATA_W = 32
);
  logic [CH_NUM-1:0]        slave_req;
  logic [CH_NUM*ADDR_W-1:0] slave_waddr;
  logic [CH_NUM*LEN_W-1:0]  slave_wlen;
  logic [CH_NUM*DATA_W-1:0] slave_data;
  logic [CH_NUM-1:0]        slave_ren;
  logic [CH_NUM-1:0]        slave_valid;
  logic                     ready;
  logic                     ddr_write_finish;
  logic [ADDR_W-1:0]        arb_wddr_addr;
  logic [LEN_W-1:0]         arb_wddr_len;
  logic                     ddr_Rfifo_en;
  logic [DATA_W-1:0]        ddr_Rfifo_data;
  logic                     mem_wen;
  logic                     mem_wen_valid;
  logic                     arb_busy;
  logic                     ovr_err;

  modport master (
    input  slave_req, slave_waddr, slave_wlen, slave_data, ready, ddr_write_finish,
           ddr_Rfifo_en, mem_wen_valid,
    output slave_ren, slave_valid, arb_wddr_addr, arb_wddr_len, ddr_Rfifo_data, mem_wen,
           arb_busy, ovr_err
  );

  modport slave (
    output slave_req, slave_waddr, slave_wlen, slave_data, ready, ddr_write_finish,
           ddr_Rfifo_en, mem_wen_valid,
    input  slave_ren, slave_valid, arb_wddr_addr, arb_wddr_len, ddr_Rfifo_data, mem_wen,
           arb_busy, ovr_err
  );
endinterface

// File: rtl/ddr_wr_arb_rr.sv
// N-channel DDR write arbiter: fixed-priority or round-robin grant with an urgent
// override channel, mem_wen handshake, beat-counted read forwarding and over-read flag.
module ddr_wr_arb_rr #(
  parameter int unsigned CH_NUM   = 10,
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 1,
  parameter int unsigned PRIO_EN  = 1,
  parameter int unsigned PRIO_CH  = 9
) (
  input logic              ddr_clk,
  input logic              sys_rstn,
  ddr_wr_arb_rr_if.master  bus
);

  localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] XFER     = 2'd2;

  logic [1:0]        state_q;
  logic [CH_NUM-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              mem_wen_q;
  logic              ovr_q;
  logic [LEN_W:0]    beat_q;
  logic [GW-1:0]     last_gnt_q;

  logic [CH_NUM-1:0] elig;
  logic [GW-1:0]     win;
  logic              win_found;
  logic              win_rr;
  logic [CH_NUM-1:0] win_oh;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic              can_pull;
  logic              pull;
  logic              over;
  logic [CH_NUM-1:0] ren;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    for (int i = 0; i < int'(CH_NUM); i++) begin
      elig[i] = bus.slave_req[i] & (|bus.slave_wlen[i*LEN_W +: LEN_W]);
    end
  end

  // Loops run backwards so the last hit, i.e. the first in search order, wins.
  always_comb begin
    int unsigned cand;
    win       = '0;
    win_found = 1'b0;
    win_rr    = 1'b0;
    cand      = 0;
    if (PRIO_EN != 0 && elig[PRIO_CH]) begin
      win       = GW'(PRIO_CH);
      win_found = 1'b1;
    end else if (ARB_MODE == 0) begin
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win       = GW'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = CH_NUM; k >= 1; k--) begin
        cand = (32'(last_gnt_q) + k) % CH_NUM;
        if (elig[GW'(cand)]) begin
          win       = GW'(cand);
          win_found = 1'b1;
        end
      end
      win_rr = win_found;
    end
  end

  always_comb begin
    win_oh   = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (win == GW'(i)) begin
        win_oh[i] = 1'b1;
        win_addr  = bus.slave_waddr[i*ADDR_W +: ADDR_W];
        win_len   = bus.slave_wlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign can_pull = beat_q < {1'b0, len_q};
  assign pull     = |ren;
  assign over     = bus.ddr_Rfifo_en & (|valid_q) & (beat_q == {1'b0, len_q});

  always_comb begin
    ren   = '0;
    rdata = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      ren[i] = bus.ddr_Rfifo_en & valid_q[i] & can_pull;
      if (valid_q[i]) rdata = rdata | bus.slave_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      mem_wen_q  <= 1'b0;
      ovr_q      <= 1'b0;
      beat_q     <= '0;
      last_gnt_q <= GW'(CH_NUM - 1);
    end else begin
      if (over) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            valid_q <= win_oh;
            addr_q  <= win_addr;
            len_q   <= win_len;
            beat_q  <= '0;
            state_q <= WAIT_RDY;
            if (win_rr) last_gnt_q <= win;
          end
        end
        WAIT_RDY, XFER: begin
          // Finish wins over everything, including a same-cycle mem_wen_valid.
          if (bus.ddr_write_finish) begin
            valid_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            mem_wen_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= IDLE;
          end else begin
            if (pull) beat_q <= beat_q + 1'b1;
            if (state_q == WAIT_RDY) begin
              if (bus.ready) begin
                mem_wen_q <= 1'b1;
                state_q   <= XFER;
              end
            end else if (bus.mem_wen_valid) begin
              mem_wen_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.slave_ren      = ren;
  assign bus.slave_valid    = valid_q;
  assign bus.arb_wddr_addr  = addr_q;
  assign bus.arb_wddr_len   = len_q;
  assign bus.ddr_Rfifo_data = rdata;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.arb_busy       = state_q != IDLE;
  assign bus.ovr_err        = ovr_q;

endmodule
